wall_map_writer: RTL

- Owns and writes the 384-bit tile wall bitmap that the wall-lookup logic reads.
- Map is 16 columns × 24 rows of 16-pixel tiles; bit index = row*16 + col.
- Bulk-loads a level from the maze ROM, one 16-bit row per address.
- Accepts single-tile set/clear writes through a valid/ready handshake for runtime map edits such as doors and gates.

---
 rtl/wall_pkg.sv | 39 +++
 rtl/wall_map_writer_if.sv | 13 +
 rtl/wall_map_writer.sv | 105 ++++++++++
 3 files changed

// File: rtl/wall_pkg.sv
// Shared map geometry, tile indexing and FSM state type for the tile wall bitmap.
// border_mask() supplies the wall ring applied when WALL_BORDER_EN is defined.
package wall_pkg;

  localparam int MAP_COLS   = 16;
  localparam int MAP_ROWS   = 24;
  localparam int MAP_BITS   = 384;
  localparam int TILE_SHIFT = 4;

  typedef logic [3:0] tile_col_t;
  typedef logic [4:0] tile_row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } wmw_state_t;

  function automatic logic [8:0] tile_index(input tile_row_t row, input tile_col_t col);
    return 9'((32'(row) << TILE_SHIFT) | 32'(col));
  endfunction

  // Outer ring of tiles: row 0, last row, column 0 and last column.
  function automatic logic [MAP_BITS-1:0] border_mask();
    logic [MAP_BITS-1:0] m;
    m = {MAP_BITS{1'b0}};
    for (int r = 0; r < MAP_ROWS; r++) begin
      for (int c = 0; c < MAP_COLS; c++) begin
        if (r == 0 || r == MAP_ROWS - 1 || c == 0 || c == MAP_COLS - 1) begin
          m[r*MAP_COLS+c] = 1'b1;
        end else begin
          m[r*MAP_COLS+c] = 1'b0;
        end
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/wall_map_writer_if.sv
// Single-tile write request channel (valid/ready) into the wall map writer.
interface wall_map_writer_if;
  import wall_pkg::*;

  logic      wrValid;
  logic      wrReady;
  tile_col_t wrCol;
  tile_row_t wrRow;
  logic      wrData;

  modport master (output wrValid, output wrCol, output wrRow, output wrData, input wrReady);
  modport slave  (input wrValid, input wrCol, input wrRow, input wrData, output wrReady);
endinterface

// File: rtl/wall_map_writer.sv
// Owns the 16x24 tile wall bitmap: bulk ROM level load plus runtime single-tile edits.
// Optional macro WALL_BORDER_EN keeps the outer ring of tiles permanently set to wall.
module wall_map_writer
  import wall_pkg::*;
#(
  parameter int COLS = MAP_COLS,
  parameter int ROWS = MAP_ROWS
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 loadStart,
  output logic [4:0]           romAddr,
  input  logic [COLS-1:0]      romData,
  wall_map_writer_if.slave     wr,
  output logic                 busy,
  output logic                 loadDone,
  output logic [ROWS*COLS-1:0] wallData
);

`ifdef WALL_BORDER_EN
  localparam logic [MAP_BITS-1:0] FORCE_MASK = border_mask();
`else
  localparam logic [MAP_BITS-1:0] FORCE_MASK = {MAP_BITS{1'b0}};
`endif

  localparam tile_row_t LAST_ROW = tile_row_t'(ROWS - 1);

  wmw_state_t          state_r;
  tile_row_t           req_row_r;
  tile_row_t           cap_row_r;
  logic                cap_valid_r;
  logic                busy_r;
  logic                load_done_r;
  logic [MAP_BITS-1:0] wall_r;
  logic [8:0]          wr_idx_s;
  logic [8:0]          cap_base_s;

  assign wr_idx_s   = tile_index(wr.wrRow, wr.wrCol);
  assign cap_base_s = tile_index(cap_row_r, 4'd0);

  // Tile writes are only taken in IDLE when no load is being kicked off.
  always_comb begin
    wr.wrReady = 1'b0;
    if (state_r == IDLE && !loadStart) begin
      wr.wrReady = 1'b1;
    end else begin
      wr.wrReady = 1'b0;
    end
  end

  // Load sequencer, ROM row capture (one cycle behind the address) and tile edits.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r     <= IDLE;
      req_row_r   <= 5'd0;
      cap_row_r   <= 5'd0;
      cap_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      load_done_r <= 1'b0;
      wall_r      <= FORCE_MASK;
    end else begin
      load_done_r <= 1'b0;
      cap_valid_r <= 1'b0;
      cap_row_r   <= req_row_r;
      if (cap_valid_r) begin
        wall_r[cap_base_s +: 16] <= romData | FORCE_MASK[cap_base_s +: 16];
      end
      case (state_r)
        IDLE: begin
          if (loadStart) begin
            state_r   <= LOAD;
            req_row_r <= 5'd0;
            busy_r    <= 1'b1;
          end else if (wr.wrValid && wr.wrRow <= LAST_ROW) begin
            // Out-of-range rows are acknowledged but dropped.
            wall_r[wr_idx_s] <= wr.wrData | FORCE_MASK[wr_idx_s];
          end
        end
        LOAD: begin
          cap_valid_r <= 1'b1;
          if (req_row_r == LAST_ROW) begin
            state_r <= FLUSH;
          end else begin
            req_row_r <= req_row_r + 5'd1;
          end
        end
        FLUSH: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          load_done_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign romAddr  = req_row_r;
  assign busy     = busy_r;
  assign loadDone = load_done_r;
  assign wallData = wall_r;

endmodule
